// File: rtl/pe_if.sv
// Systolic PE data/control bundle: operands in from top/left, results out right/bottom.
interface pe_if;
  logic        output_stationary;
  logic        preload_valid;
  logic [63:0] preload_data;
  logic [63:0] in_top;
  logic [63:0] in_left;
  logic [63:0] out_right;
  logic [63:0] out_bottom;

  modport master (
    output output_stationary, preload_valid, preload_data, in_top, in_left,
    input  out_right, out_bottom
  );

  modport slave (
    input  output_stationary, preload_valid, preload_data, in_top, in_left,
    output out_right, out_bottom
  );
endinterface

// File: rtl/pe.sv
// Binary64 systolic processing element: weight-stationary MAC or output-stationary accumulate.
// Subnormals flush to signed zero, overflow goes to signed infinity, NaNs are canonical.
module pe (
  input logic clk,
  input logic reset,
  pe_if.slave bus
);

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic [63:0] weight_reg, acc_reg, right_reg, bot_reg;
  logic [63:0] ws_mac, os_mac;

  // Round-to-nearest-even on a normalised 1.mant significand, then range-check the exponent.
  function automatic logic [63:0] pack_round(logic s, int e, logic [51:0] mant, logic g, logic st);
    logic [52:0] mr;
    int          ee;
    mr = {1'b0, mant} + 53'(g & (st | mant[0]));
    ee = e + int'(mr[52]);
    if (ee >= 2047) return {s, 11'h7FF, 52'h0};
    if (ee <= 0)    return {s, 63'h0};
    return {s, 11'(ee), mr[51:0]};
  endfunction

  function automatic logic [63:0] fp_mul(logic [63:0] a, logic [63:0] b);
    logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [105:0] p;
    int           e;
    s      = a[63] ^ b[63];
    a_nan  = (&a[62:52]) && (|a[51:0]);
    b_nan  = (&b[62:52]) && (|b[51:0]);
    a_inf  = (&a[62:52]) && !(|a[51:0]);
    b_inf  = (&b[62:52]) && !(|b[51:0]);
    a_zero = !(|a[62:52]);
    b_zero = !(|b[62:52]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf)   return {s, 11'h7FF, 52'h0};
    if (a_zero || b_zero) return {s, 63'h0};
    p = {53'h0, 1'b1, a[51:0]} * {53'h0, 1'b1, b[51:0]};
    e = int'(a[62:52]) + int'(b[62:52]) - 1023;
    if (p[105]) return pack_round(s, e + 1, p[104:53], p[52], |p[51:0]);
    return pack_round(s, e, p[103:52], p[51], |p[50:0]);
  endfunction

  function automatic logic [63:0] fp_add(logic [63:0] a, logic [63:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sub;
    logic [63:0] x, y;
    logic [10:0] d;
    logic [55:0] mx, my, sh, n;
    logic [56:0] sum;
    int          e, lz;
    a_nan  = (&a[62:52]) && (|a[51:0]);
    b_nan  = (&b[62:52]) && (|b[51:0]);
    a_inf  = (&a[62:52]) && !(|a[51:0]);
    b_inf  = (&b[62:52]) && !(|b[51:0]);
    a_zero = !(|a[62:52]);
    b_zero = !(|b[62:52]);
    if (a_nan || b_nan || (a_inf && b_inf && (a[63] != b[63]))) return QNAN;
    if (a_inf)  return a;
    if (b_inf)  return b;
    if (a_zero && b_zero) return {a[63] & b[63], 63'h0};
    if (a_zero) return b;
    if (b_zero) return a;
    // x is the larger magnitude; it sets the result sign and the base exponent.
    if (a[62:0] >= b[62:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[62:52] - y[62:52];
    mx = {1'b1, x[51:0], 3'b000};
    my = {1'b1, y[51:0], 3'b000};
    if (d >= 11'd56) begin
      sh = 56'h1;
    end else begin
      sh = my >> d;
      if ((sh << d) != my) sh[0] = 1'b1;
    end
    sub = x[63] ^ y[63];
    sum = sub ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
    if (sum == '0) return 64'h0;
    e = int'(x[62:52]);
    if (sum[56]) begin
      n    = sum[56:1];
      n[0] = n[0] | sum[0];
      e    = e + 1;
    end else begin
      lz = 0;
      for (int i = 0; i < 56; i++) begin
        if (sum[i]) lz = 55 - i;
      end
      n = sum[55:0] << lz;
      e = e - lz;
    end
    return pack_round(x[63], e, n[54:3], n[2], n[1] | n[0]);
  endfunction

  assign ws_mac = fp_add(fp_mul(bus.in_left, weight_reg), bus.in_top);
  assign os_mac = fp_add(acc_reg, fp_mul(bus.in_left, bus.in_top));

  always_ff @(posedge clk) begin
    if (reset) begin
      weight_reg <= 64'h0;
      acc_reg    <= 64'h0;
      right_reg  <= 64'h0;
      bot_reg    <= 64'h0;
    end else begin
      right_reg <= bus.in_left;
      if (!bus.output_stationary) begin
        bot_reg <= ws_mac;
        if (bus.preload_valid) weight_reg <= bus.preload_data;
      end else begin
        bot_reg <= bus.in_top;
        if (!bus.preload_valid) acc_reg <= os_mac;
      end
    end
  end

  assign bus.out_right  = right_reg;
  // Drain path is combinational so the sum appears in the same cycle preload_valid rises.
  assign bus.out_bottom = (bus.output_stationary && bus.preload_valid) ? acc_reg : bot_reg;

endmodule

// File: tb/tb_pe.sv
// Bench for pe: real-arithmetic reference model checked every cycle, plus directed literal cases.
module tb_pe;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  logic [63:0] m_w, m_acc, m_right, m_bot;

  always #5 clk = ~clk;

  pe_if bus ();
  pe dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [63:0] r2b(real r);
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] flush(logic [63:0] x);
    if (x[62:52] == 11'h0) return {x[63], 63'h0};
    return x;
  endfunction

  function automatic logic [63:0] canon(real r);
    logic [63:0] x;
    x = $realtobits(r);
    if ((&x[62:52]) && (|x[51:0])) return QNAN;
    return flush(x);
  endfunction

  function automatic logic [63:0] m_mul(logic [63:0] a, logic [63:0] b);
    return canon($bitstoreal(flush(a)) * $bitstoreal(flush(b)));
  endfunction

  function automatic logic [63:0] m_add(logic [63:0] a, logic [63:0] b);
    return canon($bitstoreal(flush(a)) + $bitstoreal(flush(b)));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: the behaviour of each mode stated directly in real arithmetic.
  always @(posedge clk) begin
    if (reset) begin
      m_w = 64'h0; m_acc = 64'h0; m_right = 64'h0; m_bot = 64'h0;
    end else begin
      m_right = bus.in_left;
      if (!bus.output_stationary) begin
        m_bot = m_add(m_mul(bus.in_left, m_w), bus.in_top);
        if (bus.preload_valid) m_w = bus.preload_data;
      end else begin
        m_bot = bus.in_top;
        if (!bus.preload_valid) m_acc = m_add(m_acc, m_mul(bus.in_left, bus.in_top));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_right", bus.out_right, m_right);
      check("model_out_bottom", bus.out_bottom,
            (bus.output_stationary && bus.preload_valid) ? m_acc : m_bot);
    end
  end

  task automatic drive(logic os, logic pv, logic [63:0] pd, logic [63:0] l, logic [63:0] t);
    bus.output_stationary = os;
    bus.preload_valid     = pv;
    bus.preload_data      = pd;
    bus.in_left           = l;
    bus.in_top            = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(logic os);
    reset = 1'b1;
    drive(os, 1'b0, 64'h0, 64'h0, 64'h0);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rnd_fp();
    int          k, v;
    logic        s;
    logic [63:0] t;
    k = int'($urandom_range(0, 99));
    s = 1'($urandom_range(0, 1));
    t = {$urandom, $urandom};
    if (k < 40) begin
      v = int'($urandom_range(0, 40));
      return r2b(real'(v - 20) * 0.5);
    end
    if (k < 85) return {s, 11'(983 + $urandom_range(0, 80)), t[51:0]};
    if (k < 92) return {s, 11'($urandom_range(1, 2046)), t[51:0]};
    if (k < 95) return {s, 63'h0};
    if (k < 97) return {s, 11'h0, t[51:1], 1'b1};
    if (k < 98) return {s, 11'h7FF, 52'h0};
    return {s, 11'h7FF, t[51:1], 1'b1};
  endfunction

  initial begin
    logic os;
    reset = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    check("pin_mul", m_mul(r2b(2.0), r2b(3.0)), 64'h4018_0000_0000_0000);
    check("pin_neg", m_add(r2b(-6.0), r2b(1.0)), 64'hC014_0000_0000_0000);
    check("pin_inf0", m_mul(64'h7FF0_0000_0000_0000, 64'h0), QNAN);
    check("pin_sub", m_add(r2b(1.0), 64'h0000_0000_0000_0001), 64'h3FF0_0000_0000_0000);
    check("pin_zero", m_add(64'h8000_0000_0000_0000, 64'h0), 64'h0);

    tick();
    chk_en = 1'b1;
    do_reset(1'b0);
    check("ws_reset_right", bus.out_right, 64'h0);
    check("ws_reset_bottom", bus.out_bottom, 64'h0);

    // WS basic
    drive(1'b0, 1'b1, r2b(2.0), 64'h0, 64'h0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 64'h0, r2b(real'(i)), r2b(0.5 * real'(i)));
      tick();
      check("ws_basic_bottom", bus.out_bottom, r2b(2.5 * real'(i)));
      check("ws_basic_right", bus.out_right, r2b(real'(i)));
    end

    // WS weight update: the preload edge still uses the old weight
    drive(1'b0, 1'b1, r2b(3.0), 64'h0, 64'h0);
    tick();
    drive(1'b0, 1'b0, 64'h0, r2b(2.0), r2b(1.0));
    tick();
    check("ws_w3", bus.out_bottom, r2b(7.0));
    drive(1'b0, 1'b1, r2b(5.0), r2b(2.0), r2b(1.0));
    tick();
    check("ws_w_old", bus.out_bottom, r2b(7.0));
    drive(1'b0, 1'b0, 64'h0, r2b(2.0), r2b(1.0));
    tick();
    check("ws_w5", bus.out_bottom, r2b(11.0));

    // OS accumulate
    do_reset(1'b1);
    drive(1'b1, 1'b0, 64'h0, r2b(1.0), r2b(2.0)); tick();
    drive(1'b1, 1'b0, 64'h0, r2b(2.0), r2b(3.0)); tick();
    drive(1'b1, 1'b0, 64'h0, r2b(3.0), r2b(4.0)); tick();
    drive(1'b1, 1'b0, 64'h0, 64'h0, 64'h0);       tick();
    drive(1'b1, 1'b1, 64'h0, 64'h0, 64'h0);
    #1;
    check("os_drain20", bus.out_bottom, r2b(20.0));
    tick();

    // OS re-accumulate, with reset while draining
    do_reset(1'b1);
    drive(1'b1, 1'b0, 64'h0, r2b(5.0), r2b(2.0)); tick();
    drive(1'b1, 1'b0, 64'h0, 64'h0, 64'h0);       tick();
    drive(1'b1, 1'b1, 64'h0, 64'h0, 64'h0);
    #1;
    check("os_drain10", bus.out_bottom, r2b(10.0));
    reset = 1'b1;
    tick();
    check("os_reset_acc", bus.out_bottom, 64'h0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 64'h0, r2b(3.0), r2b(4.0)); tick();
    drive(1'b1, 1'b0, 64'h0, r2b(2.0), r2b(1.0)); tick();
    drive(1'b1, 1'b0, 64'h0, 64'h0, 64'h0);       tick();
    drive(1'b1, 1'b1, 64'h0, 64'h0, 64'h0);
    #1;
    check("os_drain14", bus.out_bottom, r2b(14.0));
    tick();
    do_reset(1'b1);
    check("os_reset_right", bus.out_right, 64'h0);
    check("os_reset_bottom", bus.out_bottom, 64'h0);

    // WS zero and negatives
    do_reset(1'b0);
    drive(1'b0, 1'b1, r2b(7.0), 64'h0, 64'h0); tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);    tick();
    check("ws_zero", bus.out_bottom, 64'h0);
    drive(1'b0, 1'b1, r2b(-2.0), 64'h0, 64'h0);      tick();
    drive(1'b0, 1'b0, 64'h0, r2b(3.0), r2b(1.0));    tick();
    check("ws_neg5", bus.out_bottom, r2b(-5.0));
    drive(1'b0, 1'b0, 64'h0, r2b(-4.0), r2b(2.0));   tick();
    check("ws_pos10", bus.out_bottom, r2b(10.0));

    // Specials
    drive(1'b0, 1'b0, 64'h0, 64'h7FF0_0000_0000_0001, r2b(1.0)); tick();
    check("ws_nan", bus.out_bottom, QNAN);
    drive(1'b0, 1'b1, 64'h0, 64'h0, 64'h0); tick();
    drive(1'b0, 1'b0, 64'h0, 64'h7FF0_0000_0000_0000, r2b(1.0)); tick();
    check("ws_inf_x0", bus.out_bottom, QNAN);

    // Randomised traffic, checked every cycle against the model
    do_reset(1'b0);
    os = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) os = ~os;
      drive(os, ($urandom_range(0, 99) < 20), rnd_fp(), rnd_fp(), rnd_fp());
      tick();
    end
    reset = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
